// File: rtl/seq_chk_pkg.sv
// seq_chk_pkg: shared constants, reference sequence and FSM states for the sequence checker
package seq_chk_pkg;
  localparam int DATA_W = 8;
  localparam int SEQ_LEN = 8;
  localparam int IDX_W = $clog2(SEQ_LEN);
  localparam logic [DATA_W-1:0] SEQ_START = 8'hAF;
  localparam logic [DATA_W-1:0] SEQ_ROM [SEQ_LEN] = '{8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D};
  typedef enum logic {ST_SEARCH, ST_LOCKED} state_e;
endpackage

// File: rtl/sequence_checker_if.sv
// sequence_checker_if: data stream in, lock/mismatch/error status out
interface sequence_checker_if #(parameter int DATA_W = 8, parameter int ERR_CNT_W = 16);
  logic enable;
  logic [DATA_W-1:0] data;
  logic locked;
  logic mismatch;
  logic [DATA_W-1:0] expected;
  logic seq_wrap;
  logic [ERR_CNT_W-1:0] err_count;
  modport master (output enable, data, input locked, mismatch, expected, seq_wrap, err_count);
  modport slave (input enable, data, output locked, mismatch, expected, seq_wrap, err_count);
endinterface

// File: rtl/seq_chk_rom.sv
// seq_chk_rom: combinational index to expected-word lookup
module seq_chk_rom import seq_chk_pkg::*; (
  input  logic [IDX_W-1:0]  idx_i,
  output logic [DATA_W-1:0] word_o
);
  assign word_o = SEQ_ROM[idx_i];
endmodule

// File: rtl/sequence_checker.sv
// sequence_checker: locks on 0xAF and checks the repeating reference stream; SEQ_CHK_RESYNC_EN lets a stray 0xAF realign while locked
module sequence_checker import seq_chk_pkg::*; #(
  parameter int ERR_CNT_W = 16,
  parameter int LOSS_THRESH = 3
) (
  input logic clk,
  input logic reset,
  sequence_checker_if.slave bus
);
  localparam logic [2:0] THR = 3'(LOSS_THRESH);
  state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [2:0] miss_q, miss_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic mis_q, mis_d, wrap_q, wrap_d;
  logic [DATA_W-1:0] exp_w;
  logic last, hit, resync, drop;
  seq_chk_rom u_rom (.idx_i(idx_q), .word_o(exp_w));
`ifdef SEQ_CHK_RESYNC_EN
  assign resync = !hit && bus.data == SEQ_START;
`else
  assign resync = 1'b0;
`endif
  assign last = idx_q == IDX_W'(SEQ_LEN - 1);
  assign hit = bus.data == exp_w;
  assign drop = !hit && !resync && (miss_q + 3'd1 == THR);
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    miss_d = miss_q;
    err_d = err_q;
    mis_d = 1'b0;
    wrap_d = 1'b0;
    if (bus.enable && state_q == ST_SEARCH) begin
      state_d = bus.data == SEQ_START ? ST_LOCKED : ST_SEARCH;
      idx_d = bus.data == SEQ_START ? IDX_W'(1) : '0;
    end else if (bus.enable) begin
      mis_d = !hit;
      err_d = (hit || &err_q) ? err_q : err_q + 1'b1;
      wrap_d = last && !drop;
      miss_d = (hit || resync || drop) ? '0 : miss_q + 3'd1;
      idx_d = drop ? '0 : resync ? IDX_W'(1) : last ? '0 : idx_q + 1'b1;
      state_d = drop ? ST_SEARCH : ST_LOCKED;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_SEARCH;
      idx_q <= '0;
      miss_q <= '0;
      err_q <= '0;
      mis_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      miss_q <= miss_d;
      err_q <= err_d;
      mis_q <= mis_d;
      wrap_q <= wrap_d;
    end
  end
  assign bus.locked = state_q == ST_LOCKED;
  assign bus.mismatch = mis_q;
  assign bus.expected = exp_w;
  assign bus.seq_wrap = wrap_q;
  assign bus.err_count = err_q;
endmodule
